// File: rtl/barycentric_pixel_scanner_pkg.sv
// Shared rasterizer definitions: scanner states, screen size, default widths and
// the fixed-point pixel-centre helper used by the scanner and the interpolator bench.
package barycentric_pixel_scanner_pkg;

  localparam int DEF_XWIDTH     = 16;
  localparam int DEF_YWIDTH     = 16;
  localparam int DEF_FRAC       = 4;
  localparam int DEF_VAL_WIDTH  = 16;
  localparam int DEF_AINV_WIDTH = 16;
  localparam int SCREEN_W       = 320;
  localparam int SCREEN_H       = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBOX  = 2'd1,
    CLAMP = 2'd2,
    SCAN  = 2'd3
  } scan_state_t;

  // Integer pixel index -> fixed-point centre (p + 0.5); callers truncate to their width.
  function automatic logic signed [31:0] pixel_centre(input logic signed [31:0] p, input int frac);
    pixel_centre = (p <<< frac) | (32'sd1 <<< (frac - 1));
  endfunction

endpackage

// File: rtl/barycentric_pixel_scanner_if.sv
// Triangle-in / pixel-out bundle of the scanner. The scanner uses the slave view;
// the triangle source and pixel sink (interpolator or bench) use the master view.
interface barycentric_pixel_scanner_if #(
  parameter int XWIDTH     = barycentric_pixel_scanner_pkg::DEF_XWIDTH,
  parameter int YWIDTH     = barycentric_pixel_scanner_pkg::DEF_YWIDTH,
  parameter int VAL_WIDTH  = barycentric_pixel_scanner_pkg::DEF_VAL_WIDTH,
  parameter int AINV_WIDTH = barycentric_pixel_scanner_pkg::DEF_AINV_WIDTH,
  parameter int SCREEN_W   = barycentric_pixel_scanner_pkg::SCREEN_W,
  parameter int SCREEN_H   = barycentric_pixel_scanner_pkg::SCREEN_H
) ();

  logic                          tri_valid_in;
  logic                          tri_ready_out;
  logic [3*XWIDTH-1:0]           x_tri_in;
  logic [3*YWIDTH-1:0]           y_tri_in;
  logic [3*VAL_WIDTH-1:0]        vals_in;
  logic [AINV_WIDTH-1:0]         iarea_in;
  logic                          ready_in;
  logic                          pix_valid_out;
  logic [XWIDTH-1:0]             x_out;
  logic [YWIDTH-1:0]             y_out;
  logic [$clog2(SCREEN_W)-1:0]   hcount_out;
  logic [$clog2(SCREEN_H)-1:0]   vcount_out;
  logic [3*XWIDTH-1:0]           x_tri_out;
  logic [3*YWIDTH-1:0]           y_tri_out;
  logic [3*VAL_WIDTH-1:0]        vals_out;
  logic [AINV_WIDTH-1:0]         iarea_out;
  logic                          last_out;
  logic                          tri_done_out;

  modport master (
    output tri_valid_in, x_tri_in, y_tri_in, vals_in, iarea_in, ready_in,
    input  tri_ready_out, pix_valid_out, x_out, y_out, hcount_out, vcount_out,
           x_tri_out, y_tri_out, vals_out, iarea_out, last_out, tri_done_out
  );

  modport slave (
    input  tri_valid_in, x_tri_in, y_tri_in, vals_in, iarea_in, ready_in,
    output tri_ready_out, pix_valid_out, x_out, y_out, hcount_out, vcount_out,
           x_tri_out, y_tri_out, vals_out, iarea_out, last_out, tri_done_out
  );

endinterface

// File: rtl/barycentric_pixel_scanner_bbox_clamp.sv
// Combinational bounding-box stage: vertex min/max in integer pixels, then screen
// clamp and skip decision on the parent's registered box.
module barycentric_pixel_scanner_bbox_clamp #(
  parameter int XWIDTH     = barycentric_pixel_scanner_pkg::DEF_XWIDTH,
  parameter int YWIDTH     = barycentric_pixel_scanner_pkg::DEF_YWIDTH,
  parameter int FRAC       = barycentric_pixel_scanner_pkg::DEF_FRAC,
  parameter int AINV_WIDTH = barycentric_pixel_scanner_pkg::DEF_AINV_WIDTH,
  parameter int SCREEN_W   = barycentric_pixel_scanner_pkg::SCREEN_W,
  parameter int SCREEN_H   = barycentric_pixel_scanner_pkg::SCREEN_H
) (
  input  logic [3*XWIDTH-1:0]             x_tri_i,
  input  logic [3*YWIDTH-1:0]             y_tri_i,
  output logic signed [XWIDTH-FRAC-1:0]   xmin_o,
  output logic signed [XWIDTH-FRAC-1:0]   xmax_o,
  output logic signed [YWIDTH-FRAC-1:0]   ymin_o,
  output logic signed [YWIDTH-FRAC-1:0]   ymax_o,
  input  logic signed [XWIDTH-FRAC-1:0]   xmin_i,
  input  logic signed [XWIDTH-FRAC-1:0]   xmax_i,
  input  logic signed [YWIDTH-FRAC-1:0]   ymin_i,
  input  logic signed [YWIDTH-FRAC-1:0]   ymax_i,
  input  logic [AINV_WIDTH-1:0]           iarea_i,
  output logic signed [XWIDTH-FRAC-1:0]   cxmin_o,
  output logic signed [XWIDTH-FRAC-1:0]   cxmax_o,
  output logic signed [YWIDTH-FRAC-1:0]   cymin_o,
  output logic signed [YWIDTH-FRAC-1:0]   cymax_o,
  output logic                            skip_o
);
  import barycentric_pixel_scanner_pkg::*;

  localparam int XI = XWIDTH - FRAC;
  localparam int YI = YWIDTH - FRAC;
  localparam logic signed [XI-1:0] XLIM = XI'(SCREEN_W - 1);
  localparam logic signed [YI-1:0] YLIM = YI'(SCREEN_H - 1);

  logic signed [XI-1:0] xv [3];
  logic signed [YI-1:0] yv [3];

  // Taking the top bits of a two's-complement fixed-point value is a floor.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      xv[i] = x_tri_i[i*XWIDTH+FRAC +: XI];
      yv[i] = y_tri_i[i*YWIDTH+FRAC +: YI];
    end
    xmin_o = xv[0];
    xmax_o = xv[0];
    ymin_o = yv[0];
    ymax_o = yv[0];
    for (int i = 1; i < 3; i++) begin
      if (xv[i] < xmin_o) xmin_o = xv[i];
      if (xv[i] > xmax_o) xmax_o = xv[i];
      if (yv[i] < ymin_o) ymin_o = yv[i];
      if (yv[i] > ymax_o) ymax_o = yv[i];
    end
  end

  always_comb begin
    skip_o  = (iarea_i == '0) || xmax_i[XI-1] || ymax_i[YI-1] ||
              (xmin_i > XLIM) || (ymin_i > YLIM);
    cxmin_o = xmin_i[XI-1] ? '0 : xmin_i;
    cxmax_o = (xmax_i > XLIM) ? XLIM : xmax_i;
    cymin_o = ymin_i[YI-1] ? '0 : ymin_i;
    cymax_o = (ymax_i > YLIM) ? YLIM : ymax_i;
  end

endmodule

// File: rtl/barycentric_pixel_scanner.sv
// Rasterizer front end: accepts a triangle, clamps its bounding box to the screen and
// walks it row-major, one registered pixel centre per accepted cycle.
//
//  state | meaning
//  IDLE  | ready for a triangle; registers all triangle inputs on handshake
//  BBOX  | register vertex min/max in integer pixels
//  CLAMP | clamp box to screen; skip (done pulse) or load first pixel
//  SCAN  | present pixels, advance on ready_in, retire on last transfer
module barycentric_pixel_scanner #(
  parameter int XWIDTH     = barycentric_pixel_scanner_pkg::DEF_XWIDTH,
  parameter int YWIDTH     = barycentric_pixel_scanner_pkg::DEF_YWIDTH,
  parameter int FRAC       = barycentric_pixel_scanner_pkg::DEF_FRAC,
  parameter int VAL_WIDTH  = barycentric_pixel_scanner_pkg::DEF_VAL_WIDTH,
  parameter int AINV_WIDTH = barycentric_pixel_scanner_pkg::DEF_AINV_WIDTH,
  parameter int SCREEN_W   = barycentric_pixel_scanner_pkg::SCREEN_W,
  parameter int SCREEN_H   = barycentric_pixel_scanner_pkg::SCREEN_H
) (
  input logic                        clk_in,
  input logic                        rst_n_in,
  barycentric_pixel_scanner_if.slave scan_if
);
  import barycentric_pixel_scanner_pkg::*;

  localparam int XI = XWIDTH - FRAC;
  localparam int YI = YWIDTH - FRAC;
  localparam int HW = $clog2(SCREEN_W);
  localparam int VW = $clog2(SCREEN_H);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BBOX  = BBOX;
  localparam logic [1:0] ST_CLAMP = CLAMP;
  localparam logic [1:0] ST_SCAN  = SCAN;

  logic [1:0]               state_q, state_d;
  logic                     tri_ready_q, tri_ready_d;
  logic [3*XWIDTH-1:0]      xt_q, xt_d;
  logic [3*YWIDTH-1:0]      yt_q, yt_d;
  logic [3*VAL_WIDTH-1:0]   vals_q, vals_d;
  logic [AINV_WIDTH-1:0]    iarea_q, iarea_d;
  logic signed [XI-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, px_q, px_d;
  logic signed [YI-1:0]     ymin_q, ymin_d, ymax_q, ymax_d, py_q, py_d;
  logic                     pix_valid_q, pix_valid_d;
  logic                     last_q, last_d;

  logic signed [XI-1:0]     bb_xmin, bb_xmax, cl_xmin, cl_xmax;
  logic signed [YI-1:0]     bb_ymin, bb_ymax, cl_ymin, cl_ymax;
  logic                     skip;
  logic                     xfer;

  barycentric_pixel_scanner_bbox_clamp #(
    .XWIDTH     (XWIDTH),
    .YWIDTH     (YWIDTH),
    .FRAC       (FRAC),
    .AINV_WIDTH (AINV_WIDTH),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H)
  ) u_bbox_clamp (
    .x_tri_i (xt_q),
    .y_tri_i (yt_q),
    .xmin_o  (bb_xmin),
    .xmax_o  (bb_xmax),
    .ymin_o  (bb_ymin),
    .ymax_o  (bb_ymax),
    .xmin_i  (xmin_q),
    .xmax_i  (xmax_q),
    .ymin_i  (ymin_q),
    .ymax_i  (ymax_q),
    .iarea_i (iarea_q),
    .cxmin_o (cl_xmin),
    .cxmax_o (cl_xmax),
    .cymin_o (cl_ymin),
    .cymax_o (cl_ymax),
    .skip_o  (skip)
  );

  assign xfer = pix_valid_q & scan_if.ready_in;

  always_comb begin
    state_d     = state_q;
    xt_d        = xt_q;
    yt_d        = yt_q;
    vals_d      = vals_q;
    iarea_d     = iarea_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    px_d        = px_q;
    py_d        = py_q;
    pix_valid_d = pix_valid_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_if.tri_valid_in && tri_ready_q) begin
          xt_d    = scan_if.x_tri_in;
          yt_d    = scan_if.y_tri_in;
          vals_d  = scan_if.vals_in;
          iarea_d = scan_if.iarea_in;
          state_d = ST_BBOX;
        end
      end
      ST_BBOX: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymin_d  = bb_ymin;
        ymax_d  = bb_ymax;
        state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        if (skip) begin
          state_d = ST_IDLE;
        end else begin
          // The clamped box replaces the raw one; SCAN wraps against it.
          xmin_d      = cl_xmin;
          xmax_d      = cl_xmax;
          ymin_d      = cl_ymin;
          ymax_d      = cl_ymax;
          px_d        = cl_xmin;
          py_d        = cl_ymin;
          pix_valid_d = 1'b1;
          last_d      = (cl_xmin == cl_xmax) && (cl_ymin == cl_ymax);
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (xfer) begin
          if (last_q) begin
            pix_valid_d = 1'b0;
            last_d      = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            if (px_q == xmax_q) begin
              px_d = xmin_q;
              py_d = py_q + 1'b1;
            end else begin
              px_d = px_q + 1'b1;
            end
            last_d = (px_d == xmax_q) && (py_d == ymax_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tri_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      tri_ready_q <= 1'b0;
      xt_q        <= '0;
      yt_q        <= '0;
      vals_q      <= '0;
      iarea_q     <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      pix_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tri_ready_q <= tri_ready_d;
      xt_q        <= xt_d;
      yt_q        <= yt_d;
      vals_q      <= vals_d;
      iarea_q     <= iarea_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pix_valid_q <= pix_valid_d;
      last_q      <= last_d;
    end
  end

  // Centres are forced to zero outside a valid pixel so idle/reset outputs read 0.
  assign scan_if.x_out = pix_valid_q ? XWIDTH'(pixel_centre(32'(px_q), FRAC)) : '0;
  assign scan_if.y_out = pix_valid_q ? YWIDTH'(pixel_centre(32'(py_q), FRAC)) : '0;

  assign scan_if.tri_ready_out = tri_ready_q;
  assign scan_if.pix_valid_out = pix_valid_q;
  assign scan_if.hcount_out    = px_q[HW-1:0];
  assign scan_if.vcount_out    = py_q[VW-1:0];
  assign scan_if.x_tri_out     = xt_q;
  assign scan_if.y_tri_out     = yt_q;
  assign scan_if.vals_out      = vals_q;
  assign scan_if.iarea_out     = iarea_q;
  assign scan_if.last_out      = last_q;
  assign scan_if.tri_done_out  = ((state_q == ST_CLAMP) && skip) ||
                                 ((state_q == ST_SCAN) && xfer && last_q);

endmodule
